fwd_hazard_unit: RTL

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_pkg.sv | 25 ++
 rtl/dest_tracker.sv | 66 ++++++
 rtl/fwd_hazard_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/hazard unit: select codes,
// control FSM states and default widths.
package fwd_pkg;

  localparam int REGBITS_DEF = 5;
  localparam int SELBITS_DEF = 2;

  // Operand source selects for the EX stage.
  localparam logic [1:0] SEL_REGBNK = 2'b00;
  localparam logic [1:0] SEL_ALU    = 2'b01;
  localparam logic [1:0] SEL_MEM    = 2'b10;
  localparam logic [1:0] SEL_WB     = 2'b11;

  // Tracker slot positions.
  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/dest_tracker.sv
// Three-slot (EX, MEM, WB) record of in-flight {rd, regwrite, memread}.
// Ports: clk_i/rst_i; shift_i advance; bubble_i load an empty EX entry;
// hold_i freeze all slots; rd_i/regwrite_i/memread_i ID fields;
// rd_o/rw_o/mr_o slot contents, index 0 = EX, 1 = MEM, 2 = WB.
module dest_tracker
  import fwd_pkg::*;
#(
  parameter int REGBITS = REGBITS_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    shift_i,
  input  logic                    bubble_i,
  input  logic                    hold_i,
  input  logic [REGBITS-1:0]      rd_i,
  input  logic                    regwrite_i,
  input  logic                    memread_i,
  output logic [2:0][REGBITS-1:0] rd_o,
  output logic [2:0]              rw_o,
  output logic [2:0]              mr_o
);

  logic [2:0][REGBITS-1:0] rd_q, rd_d;
  logic [2:0]              rw_q, rw_d;
  logic [2:0]              mr_q, mr_d;

  always_comb begin
    rd_d = rd_q;
    rw_d = rw_q;
    mr_d = mr_q;
    if (shift_i && !hold_i) begin
      rd_d[SLOT_WB]  = rd_q[SLOT_MEM];
      rw_d[SLOT_WB]  = rw_q[SLOT_MEM];
      mr_d[SLOT_WB]  = mr_q[SLOT_MEM];
      rd_d[SLOT_MEM] = rd_q[SLOT_EX];
      rw_d[SLOT_MEM] = rw_q[SLOT_EX];
      mr_d[SLOT_MEM] = mr_q[SLOT_EX];
      if (bubble_i) begin
        rd_d[SLOT_EX] = '0;
        rw_d[SLOT_EX] = 1'b0;
        mr_d[SLOT_EX] = 1'b0;
      end else begin
        rd_d[SLOT_EX] = rd_i;
        rw_d[SLOT_EX] = regwrite_i;
        mr_d[SLOT_EX] = memread_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q <= '0;
      rw_q <= '0;
      mr_q <= '0;
    end else begin
      rd_q <= rd_d;
      rw_q <= rw_d;
      mr_q <= mr_d;
    end
  end

  assign rd_o = rd_q;
  assign rw_o = rw_q;
  assign mr_o = mr_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects and load-use stall control for a 5-stage pipe.
// Ports: i_clk, i_reset (async, high); i_id_rs/i_id_rt/i_id_rd and
// i_id_regwrite/i_id_memread from ID; i_halt debug freeze;
// o_sel_a/o_sel_b registered EX operand selects; o_stall hold + bubble.
// Build option FWD_HAZARD_FWD_EN: enables forwarding; when undefined the
// selects stay at the register bank and any pending writer stalls ID.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REGBITS = REGBITS_DEF,
  parameter int SELBITS = SELBITS_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [REGBITS-1:0] i_id_rs,
  input  logic [REGBITS-1:0] i_id_rt,
  input  logic [REGBITS-1:0] i_id_rd,
  input  logic               i_id_regwrite,
  input  logic               i_id_memread,
  input  logic               i_halt,
  output logic [SELBITS-1:0] o_sel_a,
  output logic [SELBITS-1:0] o_sel_b,
  output logic               o_stall
);

  logic [2:0][REGBITS-1:0] trk_rd;
  logic [2:0]              trk_rw;
  logic [2:0]              trk_mr;
  logic                    trk_shift;
  logic                    trk_bubble;

  state_e state_q, state_d;
  state_e saved_q, saved_d;
  logic   frz_q, frz_d;
  logic   stall_c;
  logic   hazard;

  logic [SELBITS-1:0] sel_a_q, sel_a_d;
  logic [SELBITS-1:0] sel_b_q, sel_b_d;
  logic [2:0]         hit_a, hit_b;
  logic               unused_trk;

  dest_tracker #(
    .REGBITS(REGBITS)
  ) u_trk (
    .clk_i     (i_clk),
    .rst_i     (i_reset),
    .shift_i   (trk_shift),
    .bubble_i  (trk_bubble),
    .hold_i    (i_halt),
    .rd_i      (i_id_rd),
    .regwrite_i(i_id_regwrite),
    .memread_i (i_id_memread),
    .rd_o      (trk_rd),
    .rw_o      (trk_rw),
    .mr_o      (trk_mr)
  );

  // r0 is hardwired, so a zero source never matches a slot.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      hit_a[k] = trk_rw[k] && (trk_rd[k] == i_id_rs) && (i_id_rs != '0);
      hit_b[k] = trk_rw[k] && (trk_rd[k] == i_id_rt) && (i_id_rt != '0);
    end
  end

  // Nearest producer wins.
  function automatic logic [SELBITS-1:0] pick(input logic [2:0] h);
    logic [SELBITS-1:0] s;
    s = SELBITS'(SEL_REGBNK);
    priority case (1'b1)
      h[SLOT_EX]:  s = SELBITS'(SEL_ALU);
      h[SLOT_MEM]: s = SELBITS'(SEL_MEM);
      h[SLOT_WB]:  s = SELBITS'(SEL_WB);
      default:     s = SELBITS'(SEL_REGBNK);
    endcase
    return s;
  endfunction

`ifdef FWD_HAZARD_FWD_EN
  assign hazard = trk_mr[SLOT_EX] &&
    (((trk_rd[SLOT_EX] == i_id_rs) && (i_id_rs != '0)) ||
     ((trk_rd[SLOT_EX] == i_id_rt) && (i_id_rt != '0)));
`else
  assign hazard = |{hit_a, hit_b};
`endif

  assign unused_trk = ^trk_mr;

  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    frz_d      = frz_q;
    stall_c    = 1'b0;
    trk_shift  = 1'b0;
    trk_bubble = 1'b0;
    unique case (state_q)
      RUN: begin
        stall_c    = hazard;
        trk_shift  = 1'b1;
        trk_bubble = hazard;
        if (hazard) state_d = STALL;
      end
      STALL: begin
        trk_shift = 1'b1;
`ifdef FWD_HAZARD_FWD_EN
        state_d = RUN;
`else
        // Keep bubbling until the writer has left WB.
        stall_c    = hazard;
        trk_bubble = hazard;
        state_d    = hazard ? STALL : RUN;
`endif
      end
      HALT: begin
        stall_c = frz_q;
        if (!i_halt) state_d = saved_q;
      end
      default: state_d = RUN;
    endcase
    // Halt beats a same-cycle hazard; the hazard is re-seen on resume.
    if (i_halt && (state_q != HALT)) begin
      state_d   = HALT;
      saved_d   = state_q;
      frz_d     = stall_c;
      trk_shift = 1'b0;
    end
  end

  always_comb begin
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    if (trk_shift) begin
`ifdef FWD_HAZARD_FWD_EN
      sel_a_d = pick(hit_a);
      sel_b_d = pick(hit_b);
`else
      sel_a_d = SELBITS'(SEL_REGBNK);
      sel_b_d = SELBITS'(SEL_REGBNK);
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= RUN;
      saved_q <= RUN;
      frz_q   <= 1'b0;
      sel_a_q <= '0;
      sel_b_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      frz_q   <= frz_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign o_sel_a = sel_a_q;
  assign o_sel_b = sel_b_q;
  assign o_stall = stall_c;

endmodule
